// File: rtl/leb128_framer.sv
// rtl/leb128_framer.sv - LEB128 byte-stream framer packing up to MB bytes per frame.
// Optional overlong-encoding error/discard path enabled by LEB128_FRAMER_ERR_EN.
module leb128_framer #(
    parameter  int N  = 64,
    localparam int MB = N / 7 + 1,
    localparam int M  = MB * 8,
    localparam int CW = $clog2(MB) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [7:0]    s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [0:M-1]  m_data,
    output logic [CW-1:0] m_count,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [CW-1:0] count_q, count_d;
    logic [0:M-1]  data_q, data_d;
    logic          s_fire, m_fire;

`ifdef LEB128_FRAMER_ERR_EN
    logic          err_q, err_d;
`endif

    assign s_fire = s_valid && s_ready;
    assign m_fire = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            count_q <= '0;
            data_q  <= '0;
`ifdef LEB128_FRAMER_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            data_q  <= data_d;
`ifdef LEB128_FRAMER_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        data_d  = data_q;
`ifdef LEB128_FRAMER_ERR_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE, COLLECT: begin
                if (s_fire) begin
                    // Constant-index slot select keeps the byte placement a plain mux per slot.
                    for (int k = 0; k < MB; k++) begin
                        if (idx_q == CW'(k)) begin
                            data_d[k*8 +: 8] = s_data;
                        end
                    end
                    if (!s_data[7]) begin
                        state_d = HOLD;
                        count_d = idx_q + CW'(1);
                    end else if (idx_q != CW'(MB - 1)) begin
                        state_d = COLLECT;
                        idx_d   = idx_q + CW'(1);
                    end else begin
`ifdef LEB128_FRAMER_ERR_EN
                        state_d = DISCARD;
                        err_d   = 1'b1;
                        idx_d   = '0;
                        data_d  = '0;
`else
                        // Overlong byte closes the frame with its continuation bit kept.
                        state_d = HOLD;
                        count_d = CW'(MB);
`endif
                    end
                end
            end
            HOLD: begin
                if (m_fire) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    count_d = '0;
                    data_d  = '0;
                end
            end
            DISCARD: begin
                if (s_fire && !s_data[7]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_ready = !rst && (state_q != HOLD);
        m_valid = (state_q == HOLD);
        m_data  = data_q;
        m_count = count_q;
`ifdef LEB128_FRAMER_ERR_EN
        err     = err_q;
`else
        err     = 1'b0;
`endif
    end

endmodule

// File: tb/tb_leb128_framer.sv
// tb/tb_leb128_framer.sv - directed and random-stream bench for leb128_framer.
module tb_leb128_framer;

    localparam int MB = 10;
    localparam int M  = 80;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [7:0]    s_data;
    logic          m_valid;
    logic          m_ready;
    logic [0:M-1]  m_data;
    logic [4:0]    m_count;
    logic          err;

    int vec  = 0;
    int miss = 0;

    leb128_framer #(.N(64)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_count (m_count),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Reference packing written bit by bit: frame bit k*8+j holds byte bit 7-j.
    function automatic logic [0:M-1] pack(input logic [7:0] q[$]);
        logic [0:M-1] v;
        v = '0;
        for (int k = 0; k < q.size(); k++) begin
            for (int j = 0; j < 8; j++) begin
                v[k*8 + j] = q[k][7-j];
            end
        end
        return v;
    endfunction

    task automatic push(input logic [7:0] b);
        s_valid = 1'b1;
        s_data  = b;
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = 8'h00;
    endtask

    task automatic take();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b1; s_data = 8'h7F; m_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vec++; if (s_ready !== 1'b0) begin miss++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
        vec++; if (m_valid !== 1'b0) begin miss++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        vec++; if (m_data !== '0) begin miss++; $display("FAIL reset_m_data: got %h want 0", m_data); end
        vec++; if (m_count !== 5'd0) begin miss++; $display("FAIL reset_m_count: got %0d want 0", m_count); end
        vec++; if (err !== 1'b0) begin miss++; $display("FAIL reset_err: got %b want 0", err); end
        rst = 1'b0; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
        @(negedge clk);
        vec++; if (s_ready !== 1'b1) begin miss++; $display("FAIL reset_release_s_ready: got %b want 1", s_ready); end
        vec++; if (m_valid !== 1'b0) begin miss++; $display("FAIL reset_release_m_valid: got %b want 0", m_valid); end
    endtask

    task automatic test_single();
        logic [0:M-1] exp;
        logic [7:0]   q[$];
        q = '{8'h7F};
        exp = pack(q);
        push(8'h7F);
        vec++; if (m_valid !== 1'b1) begin miss++; $display("FAIL single_valid: got %b want 1", m_valid); end
        vec++; if (m_data !== exp) begin miss++; $display("FAIL single_data: got %h want %h", m_data, exp); end
        vec++; if (m_count !== 5'd1) begin miss++; $display("FAIL single_count: got %0d want 1", m_count); end
        vec++; if (s_ready !== 1'b0) begin miss++; $display("FAIL single_hold_ready: got %b want 0", s_ready); end
        take();
        vec++; if (m_valid !== 1'b0) begin miss++; $display("FAIL single_after_valid: got %b want 0", m_valid); end
        vec++; if (s_ready !== 1'b1) begin miss++; $display("FAIL single_after_ready: got %b want 1", s_ready); end
        vec++; if (m_data !== '0) begin miss++; $display("FAIL single_after_data: got %h want 0", m_data); end
    endtask

    task automatic test_back_to_back();
        logic [0:M-1] exp;
        logic [23:0]  head;
        logic [7:0]   q[$];
        q = '{8'hE5, 8'h8E, 8'h26};
        exp = pack(q);
        push(8'hE5);
        vec++; if (m_valid !== 1'b0) begin miss++; $display("FAIL b2b_early1: got %b want 0", m_valid); end
        push(8'h8E);
        vec++; if (m_valid !== 1'b0) begin miss++; $display("FAIL b2b_early2: got %b want 0", m_valid); end
        push(8'h26);
        head = m_data[0:23];
        vec++; if (m_valid !== 1'b1) begin miss++; $display("FAIL b2b_valid: got %b want 1", m_valid); end
        vec++; if (head !== 24'hE58E26) begin miss++; $display("FAIL b2b_head: got %h want e58e26", head); end
        vec++; if (m_data !== exp) begin miss++; $display("FAIL b2b_data: got %h want %h", m_data, exp); end
        vec++; if (m_count !== 5'd3) begin miss++; $display("FAIL b2b_count: got %0d want 3", m_count); end
        take();
    endtask

    task automatic test_hold();
        logic [0:M-1] exp;
        logic [7:0]   q[$];
        q = '{8'h01};
        exp = pack(q);
        push(8'h01);
        for (int i = 0; i < 5; i++) begin
            vec++; if (m_valid !== 1'b1) begin miss++; $display("FAIL hold_valid[%0d]: got %b want 1", i, m_valid); end
            vec++; if (m_data !== exp) begin miss++; $display("FAIL hold_data[%0d]: got %h want %h", i, m_data, exp); end
            vec++; if (m_count !== 5'd1) begin miss++; $display("FAIL hold_count[%0d]: got %0d want 1", i, m_count); end
            vec++; if (s_ready !== 1'b0) begin miss++; $display("FAIL hold_ready[%0d]: got %b want 0", i, s_ready); end
            @(negedge clk);
        end
        vec++; if (m_valid !== 1'b1) begin miss++; $display("FAIL hold_sixth_valid: got %b want 1", m_valid); end
        take();
        vec++; if (m_valid !== 1'b0) begin miss++; $display("FAIL hold_release_valid: got %b want 0", m_valid); end
        vec++; if (s_ready !== 1'b1) begin miss++; $display("FAIL hold_release_ready: got %b want 1", s_ready); end
    endtask

    task automatic test_overlong();
        logic [0:M-1] exp;
        logic [7:0]   q[$];
        q = {};
        for (int i = 0; i < MB; i++) begin
            q.push_back(8'h80);
            push(8'h80);
        end
`ifdef LEB128_FRAMER_ERR_EN
        vec++; if (err !== 1'b1) begin miss++; $display("FAIL over_err: got %b want 1", err); end
        vec++; if (m_valid !== 1'b0) begin miss++; $display("FAIL over_no_frame: got %b want 0", m_valid); end
        vec++; if (s_ready !== 1'b1) begin miss++; $display("FAIL over_discard_ready: got %b want 1", s_ready); end
        push(8'h00);
        vec++; if (err !== 1'b0) begin miss++; $display("FAIL over_err_pulse: got %b want 0", err); end
        vec++; if (m_valid !== 1'b0) begin miss++; $display("FAIL over_terminator_frame: got %b want 0", m_valid); end
        q = '{8'h7F};
        exp = pack(q);
        push(8'h7F);
        vec++; if (m_valid !== 1'b1) begin miss++; $display("FAIL over_recover_valid: got %b want 1", m_valid); end
        vec++; if (m_data !== exp) begin miss++; $display("FAIL over_recover_data: got %h want %h", m_data, exp); end
        vec++; if (m_count !== 5'd1) begin miss++; $display("FAIL over_recover_count: got %0d want 1", m_count); end
        take();
`else
        exp = pack(q);
        vec++; if (err !== 1'b0) begin miss++; $display("FAIL over_err: got %b want 0", err); end
        vec++; if (m_valid !== 1'b1) begin miss++; $display("FAIL over_valid: got %b want 1", m_valid); end
        vec++; if (m_count !== 5'd10) begin miss++; $display("FAIL over_count: got %0d want 10", m_count); end
        vec++; if (m_data !== exp) begin miss++; $display("FAIL over_data: got %h want %h", m_data, exp); end
        take();
        push(8'h00);
        vec++; if (m_valid !== 1'b1) begin miss++; $display("FAIL over_second_valid: got %b want 1", m_valid); end
        vec++; if (m_count !== 5'd1) begin miss++; $display("FAIL over_second_count: got %0d want 1", m_count); end
        vec++; if (m_data !== '0) begin miss++; $display("FAIL over_second_data: got %h want 0", m_data); end
        take();
`endif
    endtask

    task automatic test_reset_mid();
        logic [0:M-1] exp;
        logic [7:0]   q[$];
        q = '{8'h05};
        exp = pack(q);
        push(8'h81);
        push(8'h82);
        rst = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        vec++; if (s_ready !== 1'b0) begin miss++; $display("FAIL mid_rst_ready: got %b want 0", s_ready); end
        vec++; if (m_valid !== 1'b0) begin miss++; $display("FAIL mid_rst_valid: got %b want 0", m_valid); end
        rst = 1'b0;
        m_ready = 1'b0;
        push(8'h05);
        vec++; if (m_valid !== 1'b1) begin miss++; $display("FAIL mid_valid: got %b want 1", m_valid); end
        vec++; if (m_data !== exp) begin miss++; $display("FAIL mid_data: got %h want %h", m_data, exp); end
        vec++; if (m_count !== 5'd1) begin miss++; $display("FAIL mid_count: got %0d want 1", m_count); end
        take();
    endtask

    task automatic test_random();
        logic [0:M-1] exp;
        logic [7:0]   q[$];
        int           len;
        m_ready = 1'b1;
        for (int f = 0; f < 24; f++) begin
            len = $urandom_range(1, MB);
            q = {};
            for (int k = 0; k < len; k++) begin
                q.push_back({(k != len - 1), 7'($urandom_range(0, 127))});
            end
            exp = pack(q);
            for (int k = 0; k < len; k++) begin
                push(q[k]);
                if (k != len - 1) begin
                    vec++; if (m_valid !== 1'b0) begin miss++; $display("FAIL rand_early[%0d.%0d]: got %b want 0", f, k, m_valid); end
                end
            end
            vec++; if (m_valid !== 1'b1) begin miss++; $display("FAIL rand_valid[%0d]: got %b want 1", f, m_valid); end
            vec++; if (m_count !== 5'(len)) begin miss++; $display("FAIL rand_count[%0d]: got %0d want %0d", f, m_count, len); end
            vec++; if (m_data !== exp) begin miss++; $display("FAIL rand_data[%0d]: got %h want %h", f, m_data, exp); end
            @(negedge clk);
            vec++; if (m_valid !== 1'b0) begin miss++; $display("FAIL rand_dup[%0d]: got %b want 0", f, m_valid); end
        end
        m_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_overlong();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
